// File: rtl/ones_count3_pkg.sv
// Shared types and reference data for the registered 3-input ones counter.
package ones_count3_pkg;

  typedef enum logic [1:0] {
    SOP      = 2'd0,
    NAND_NOR = 2'd1,
    XOR_MAJ  = 2'd2
  } sel_e;

  localparam int unsigned NUM_IMPL = 3;
  localparam int unsigned RES_W    = 2;

  // Indexed by {a,b,c}; each entry is {y1,y0}.
  localparam logic [RES_W-1:0] COUNT3_TT [8] = '{
    2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11
  };

  function automatic logic [RES_W-1:0] ref_count3(input logic a, input logic b, input logic c);
    return COUNT3_TT[{a, b, c}];
  endfunction

endpackage

// File: rtl/count3_comb.sv
// One combinational realisation of the 3-input ones counter, picked by IMPL.
module count3_comb
  import ones_count3_pkg::*;
#(
  parameter sel_e IMPL = SOP
) (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y1,
  output logic y0
);

  if (IMPL == SOP) begin : g_sop
    assign y1 = (a & b) | (a & c) | (b & c);
    assign y0 = (~a & ~b &  c) | (~a &  b & ~c) |
                ( a & ~b & ~c) | ( a &  b &  c);
  end else if (IMPL == NAND_NOR) begin : g_nand_nor
    logic n1, n2, n3, x_ab;
    logic m1, m2, m3;
    // Four-NAND XOR for a^b, reused for the carry term.
    assign n1   = ~(a & b);
    assign n2   = ~(a & n1);
    assign n3   = ~(b & n1);
    assign x_ab = ~(n2 & n3);
    assign m1   = ~(x_ab & c);
    assign m2   = ~(x_ab & m1);
    assign m3   = ~(c & m1);
    assign y0   = ~(m2 & m3);
    assign y1   = ~(n1 & m1);
  end else begin : g_xor_maj
    logic x_ab;
    assign x_ab = a ^ b;
    assign y0   = x_ab ^ c;
    assign y1   = (a & b) | (c & x_ab);
  end

endmodule

// File: rtl/ones_count3_reg.sv
// Registered 3:2 compressor cell: selected realisation drives y1/y0, the
// other two realisations cross-check it through a sticky mismatch flag.
module ones_count3_reg
  import ones_count3_pkg::*;
#(
  parameter int unsigned SEL      = 0,
  parameter bit          CHECK_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y1,
  output logic y0,
  output logic out_valid,
  output logic mismatch
);

  if (SEL >= NUM_IMPL) begin : g_bad_sel
    $error("ones_count3_reg: SEL must be 0, 1 or 2");
  end

  logic sop_y1, sop_y0, nn_y1, nn_y0, xm_y1, xm_y0;
  logic [RES_W-1:0] res_sop, res_nn, res_xm, res_sel_c;
  logic             diff_c;

  count3_comb #(.IMPL(SOP))      u_sop      (.a(a), .b(b), .c(c), .y1(sop_y1), .y0(sop_y0));
  count3_comb #(.IMPL(NAND_NOR)) u_nand_nor (.a(a), .b(b), .c(c), .y1(nn_y1),  .y0(nn_y0));
  count3_comb #(.IMPL(XOR_MAJ))  u_xor_maj  (.a(a), .b(b), .c(c), .y1(xm_y1),  .y0(xm_y0));

  assign res_sop = {sop_y1, sop_y0};
  assign res_nn  = {nn_y1, nn_y0};
  assign res_xm  = {xm_y1, xm_y0};

  // Result select
  always_comb begin
    res_sel_c = res_sop;
    case (SEL)
      1:       res_sel_c = res_nn;
      2:       res_sel_c = res_xm;
      default: res_sel_c = res_sop;
    endcase
  end

  assign diff_c = (res_sop != res_nn) | (res_sop != res_xm) | (res_nn != res_xm);

  // Output registers and sticky cross-check flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y1        <= 1'b0;
      y0        <= 1'b0;
      out_valid <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y1 <= res_sel_c[1];
        y0 <= res_sel_c[0];
      end
      if (in_valid && CHECK_EN && diff_c) begin
        mismatch <= 1'b1;
      end
    end
  end

  // The selected realisation must always match the reference table.
  always_ff @(posedge clk) begin
    if (rst_n && in_valid) begin
      assert (res_sel_c == ref_count3(a, b, c))
        else $error("ones_count3_reg: selected result disagrees with reference");
    end
  end

endmodule

// File: tb/tb_ones_count3_reg.sv
// Directed self-checking bench for ones_count3_reg across all realisations.
module tb_ones_count3_reg;

  logic clk = 1'b0;
  logic rst_n, in_valid, a, b, c;
  logic y1_0, y0_0, ov_0, mm_0;
  logic y1_1, y0_1, ov_1, mm_1;
  logic y1_2, y0_2, ov_2, mm_2;
  logic y1_n, y0_n, ov_n, mm_n;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ones_count3_reg #(.SEL(0), .CHECK_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .y1(y1_0), .y0(y0_0), .out_valid(ov_0), .mismatch(mm_0));
  ones_count3_reg #(.SEL(1), .CHECK_EN(1'b1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .y1(y1_1), .y0(y0_1), .out_valid(ov_1), .mismatch(mm_1));
  ones_count3_reg #(.SEL(2), .CHECK_EN(1'b1)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .y1(y1_2), .y0(y0_2), .out_valid(ov_2), .mismatch(mm_2));
  ones_count3_reg #(.SEL(0), .CHECK_EN(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .y1(y1_n), .y0(y0_n), .out_valid(ov_n), .mismatch(mm_n));

  // Apply one cycle of stimulus, then sample just after the edge.
  task automatic step(input logic v, input logic [2:0] abc);
    in_valid = v;
    {a, b, c} = abc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 3'b111);
      tests++;
      if ({y1_0, y0_0, ov_0, mm_0} !== 4'b0000) begin
        fails++;
        $display("FAIL reset cyc%0d: y1y0/ov/mm=%b required 0000", i, {y1_0, y0_0, ov_0, mm_0});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [1:0] exp_tab [8];
    exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i));
      tests++;
      if ({y1_0, y0_0, ov_0, mm_0} !== {exp_tab[i], 2'b10}) begin
        fails++;
        $display("FAIL sweep sel0 abc=%03b: got %b required %b", 3'(i), {y1_0, y0_0, ov_0, mm_0}, {exp_tab[i], 2'b10});
      end
      tests++;
      if ({y1_1, y0_1, ov_1, mm_1} !== {exp_tab[i], 2'b10}) begin
        fails++;
        $display("FAIL sweep sel1 abc=%03b: got %b required %b", 3'(i), {y1_1, y0_1, ov_1, mm_1}, {exp_tab[i], 2'b10});
      end
      tests++;
      if ({y1_2, y0_2, ov_2, mm_2} !== {exp_tab[i], 2'b10}) begin
        fails++;
        $display("FAIL sweep sel2 abc=%03b: got %b required %b", 3'(i), {y1_2, y0_2, ov_2, mm_2}, {exp_tab[i], 2'b10});
      end
    end
  endtask

  task automatic test_float();
    step(1'b1, 3'b111);
    in_valid = 1'b0;
    a = 1'bz; b = 1'bz; c = 1'bz;
    @(posedge clk);
    #1;
    tests++;
    if ({y1_0, y0_0, ov_0} !== 3'b110 || $isunknown({y1_0, y0_0, ov_0, mm_0})) begin
      fails++;
      $display("FAIL float hold: y1y0/ov=%b required 110", {y1_0, y0_0, ov_0});
    end
    step(1'b0, 3'b000);
    tests++;
    if ({y1_1, y0_1, ov_1} !== 3'b110) begin
      fails++;
      $display("FAIL float hold2 sel1: y1y0/ov=%b required 110", {y1_1, y0_1, ov_1});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [3];
    logic [1:0] exp_seq [3];
    seq     = '{3'b001, 3'b011, 3'b001};
    exp_seq = '{2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, seq[i]);
      tests++;
      if ({y1_2, y0_2, ov_2} !== {exp_seq[i], 1'b1}) begin
        fails++;
        $display("FAIL toggle step%0d: y1y0/ov=%b required %b", i, {y1_2, y0_2, ov_2}, {exp_seq[i], 1'b1});
      end
    end
  endtask

  task automatic test_midstream_reset();
    step(1'b1, 3'b011);
    tests++;
    if ({y1_0, y0_0, ov_0} !== 3'b101) begin
      fails++;
      $display("FAIL midrst pre: y1y0/ov=%b required 101", {y1_0, y0_0, ov_0});
    end
    rst_n = 1'b0;
    step(1'b1, 3'b011);
    tests++;
    if ({y1_0, y0_0, ov_0} !== 3'b000) begin
      fails++;
      $display("FAIL midrst in: y1y0/ov=%b required 000", {y1_0, y0_0, ov_0});
    end
    rst_n = 1'b1;
    step(1'b1, 3'b011);
    tests++;
    if ({y1_0, y0_0, ov_0} !== 3'b101) begin
      fails++;
      $display("FAIL midrst post: y1y0/ov=%b required 101", {y1_0, y0_0, ov_0});
    end
  endtask

  task automatic test_selfcheck();
    step(1'b1, 3'b000);
    tests++;
    if ({mm_0, mm_n} !== 2'b00) begin
      fails++;
      $display("FAIL selfchk pre: mm/mm_nc=%b required 00", {mm_0, mm_n});
    end
    // Correct result for 000 is 00; invert realisation 1's y0.
    force dut.res_nn    = 2'b01;
    force dut_nc.res_nn = 2'b01;
    step(1'b1, 3'b000);
    release dut.res_nn;
    release dut_nc.res_nn;
    tests++;
    if ({mm_0, mm_n, y1_0, y0_0} !== 4'b1000) begin
      fails++;
      $display("FAIL selfchk set: mm/mm_nc/y1y0=%b required 1000", {mm_0, mm_n, y1_0, y0_0});
    end
    step(1'b1, 3'b101);
    step(1'b0, 3'b000);
    tests++;
    if ({mm_0, mm_n} !== 2'b10) begin
      fails++;
      $display("FAIL selfchk sticky: mm/mm_nc=%b required 10", {mm_0, mm_n});
    end
    rst_n = 1'b0;
    step(1'b0, 3'b000);
    rst_n = 1'b1;
    tests++;
    if ({mm_0, mm_n} !== 2'b00) begin
      fails++;
      $display("FAIL selfchk clear: mm/mm_nc=%b required 00", {mm_0, mm_n});
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    test_reset();
    test_sweep();
    test_float();
    test_back_to_back();
    test_midstream_reset();
    test_selfcheck();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
